// File: rtl/adder_pkg.sv
// Shared types and default sizing for the multicycle adder.
// Holds the IDLE/RUN state enum and default WIDTH/SLICE.
package adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit adder with carry in/out.
// Also exposes the carry into its MSB for overflow detection.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [SLICE:0] full;

  assign full = {1'b0, a} + {1'b0, b}
              + {{SLICE{1'b0}}, cin};
  assign sum  = full[SLICE-1:0];
  assign cout = full[SLICE];

  // a ^ b ^ sum at a bit position recovers the carry into it
  assign msb_cin = a[SLICE-1] ^ b[SLICE-1]
                 ^ sum[SLICE-1];

endmodule

// File: rtl/multicycle_adder.sv
// Bit-serial-by-slice adder/subtractor, one SLICE per clock.
// Define MULTICYCLE_ADDER_FLAGS_EN to build overflow/zero flags.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] operand1_in,
  input  logic [WIDTH-1:0] operand2_in,
  input  logic             subtract_in,
  input  logic             carry_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             zero_out
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CW =
    (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(NSLICES - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [SLICE-1:0] s_a;
  logic [SLICE-1:0] s_b;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  logic             s_msb_cin;
  logic             last;

  assign s_a  = op_a[cnt*SLICE +: SLICE];
  assign s_b  = op_b[cnt*SLICE +: SLICE];
  assign last = (state == RUN) && (cnt == LAST);

  adder_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a       (s_a),
    .b       (s_b),
    .cin     (carry),
    .sum     (s_sum),
    .cout    (s_cout),
    .msb_cin (s_msb_cin)
  );

  always_comb begin
    acc_next = acc;
    acc_next[cnt*SLICE +: SLICE] = s_sum;
  end

  assign ready_out = (state == IDLE);

  // acc builds the result; result_out only moves on completion
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      valid_out  <= 1'b0;
      result_out <= '0;
      carry_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            op_a  <= operand1_in;
            op_b  <= subtract_in ? ~operand2_in
                                 : operand2_in;
            carry <= subtract_in | carry_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= s_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= IDLE;
            valid_out  <= 1'b1;
            result_out <= acc_next;
            carry_out  <= s_cout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULTICYCLE_ADDER_FLAGS_EN
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      overflow_out <= 1'b0;
      zero_out     <= 1'b0;
    end else if (last) begin
      overflow_out <= s_msb_cin ^ s_cout;
      zero_out     <= (acc_next == '0);
    end
  end
`else
  logic unused_flags;
  assign unused_flags = s_msb_cin ^ last;
  assign overflow_out = 1'b0;
  assign zero_out     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder, WIDTH=32 SLICE=8.
// Random and directed operations against an arithmetic model.
module tb_multicycle_adder;

  localparam int W = 32;
  localparam int LAT = 4;
`ifdef MULTICYCLE_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         reset_in = 1'b1;
  logic         start_in = 1'b0;
  logic         ready_out;
  logic [W-1:0] operand1_in = '0;
  logic [W-1:0] operand2_in = '0;
  logic         subtract_in = 1'b0;
  logic         carry_in = 1'b0;
  logic         valid_out;
  logic [W-1:0] result_out;
  logic         carry_out;
  logic         overflow_out;
  logic         zero_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  multicycle_adder #(
    .WIDTH (32),
    .SLICE (8)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .start_in     (start_in),
    .ready_out    (ready_out),
    .operand1_in  (operand1_in),
    .operand2_in  (operand2_in),
    .subtract_in  (subtract_in),
    .carry_in     (carry_in),
    .valid_out    (valid_out),
    .result_out   (result_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out),
    .zero_out     (zero_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic exp_t model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sub,
    input logic        cin
  );
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      sr;
    logic [32:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      wide = {1'b0, a} - {1'b0, b};
      e.c  = (a >= b);
      sr   = sa - sb;
    end else begin
      wide = {1'b0, a} + {1'b0, b} + 33'(cin);
      e.c  = wide[32];
      sr   = sa + sb + longint'(cin);
    end
    e.res = wide[31:0];
    e.v = FLAGS && (sr > 64'sd2147483647 ||
                    sr < -64'sd2147483648);
    e.z = FLAGS && (e.res == 32'd0);
    return e;
  endfunction

  // Issues one operation and waits (bounded) for valid_out.
  task automatic run_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic        cin,
    output int          lat,
    output exp_t        got
  );
    @(posedge clk_in); #1;
    operand1_in = a;
    operand2_in = b;
    subtract_in = sub;
    carry_in    = cin;
    start_in    = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    operand1_in = $urandom;
    operand2_in = $urandom;
    lat = 0;
    while (!valid_out && lat < 20) begin
      @(posedge clk_in); #1;
      lat++;
    end
    if (!valid_out) lat = -1;
    got.res = result_out;
    got.c   = carry_out;
    got.v   = overflow_out;
    got.z   = zero_out;
  endtask

  task automatic test_reset;
    reset_in = 1'b1;
    start_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if ({valid_out, result_out, carry_out,
         overflow_out, zero_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b%b%b%b exp=0",
               result_out, valid_out, carry_out,
               overflow_out, zero_out);
    end
    checks++;
    if (ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", ready_out);
    end
    start_in = 1'b0;
    reset_in = 1'b0;
  endtask

  task automatic test_corners;
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic        ts [3];
    exp_t        e;
    exp_t        g;
    int          lat;
    ta = '{32'hFFFF_FFFF, 32'd5, 32'h7FFF_FFFF};
    tb = '{32'h0000_0001, 32'd7, 32'h0000_0001};
    ts = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      e = model(ta[i], tb[i], ts[i], 1'b0);
      run_op(ta[i], tb[i], ts[i], 1'b0, lat, g);
      checks++;
      if (lat !== LAT) begin
        failures++;
        $display("FAIL corner%0d_latency got=%0d exp=%0d",
                 i, lat, LAT);
      end
      checks++;
      if ({g.res, g.c, g.v, g.z} !==
          {e.res, e.c, e.v, e.z}) begin
        failures++;
        $display("FAIL corner%0d got=%h c%b v%b z%b exp=%h c%b v%b z%b",
                 i, g.res, g.c, g.v, g.z,
                 e.res, e.c, e.v, e.z);
      end
      @(posedge clk_in); #1;
      checks++;
      if (valid_out !== 1'b0 || result_out !== e.res) begin
        failures++;
        $display("FAIL corner%0d_hold got=v%b %h exp=v0 %h",
                 i, valid_out, result_out, e.res);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    exp_t        e;
    exp_t        g;
    int          lat;
    for (int i = 0; i < 30; i++) begin
      a   = $urandom;
      b   = (i % 5 == 0) ? a : $urandom;
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      e = model(a, b, sub, cin);
      run_op(a, b, sub, cin, lat, g);
      checks++;
      if (lat !== LAT ||
          {g.res, g.c, g.v, g.z} !==
          {e.res, e.c, e.v, e.z}) begin
        failures++;
        $display("FAIL random%0d a=%h b=%h s%b ci%b lat=%0d got=%h c%b v%b z%b exp=%h c%b v%b z%b",
                 i, a, b, sub, cin, lat,
                 g.res, g.c, g.v, g.z,
                 e.res, e.c, e.v, e.z);
      end
    end
  endtask

  task automatic test_start_held;
    exp_t ea;
    exp_t eb;
    int   nv;
    ea = model(32'h1000_00FF, 32'h0000_0F01, 1'b0, 1'b1);
    eb = model(32'h0000_0003, 32'h0000_0009, 1'b1, 1'b0);
    @(posedge clk_in); #1;
    operand1_in = 32'h1000_00FF;
    operand2_in = 32'h0000_0F01;
    subtract_in = 1'b0;
    carry_in    = 1'b1;
    start_in    = 1'b1;
    @(posedge clk_in); #1;
    operand1_in = 32'h0000_0003;
    operand2_in = 32'h0000_0009;
    subtract_in = 1'b1;
    carry_in    = 1'b0;
    nv = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk_in); #1;
      if (i == 5) start_in = 1'b0;
      if (valid_out) begin
        nv++;
        checks++;
        if (nv == 1 &&
            (i != 4 || result_out !== ea.res ||
             carry_out !== ea.c)) begin
          failures++;
          $display("FAIL held_first cyc=%0d got=%h c%b exp cyc=4 %h c%b",
                   i, result_out, carry_out, ea.res, ea.c);
        end
        if (nv == 2 &&
            (i != 9 || result_out !== eb.res ||
             carry_out !== eb.c)) begin
          failures++;
          $display("FAIL held_second cyc=%0d got=%h c%b exp cyc=9 %h c%b",
                   i, result_out, carry_out, eb.res, eb.c);
        end
      end
    end
    checks++;
    if (nv !== 2) begin
      failures++;
      $display("FAIL held_pulse_count got=%0d exp=2", nv);
    end
  endtask

  task automatic test_reset_midrun;
    exp_t e;
    exp_t g;
    int   lat;
    int   nv;
    @(posedge clk_in); #1;
    operand1_in = 32'hDEAD_BEEF;
    operand2_in = 32'h0101_0101;
    subtract_in = 1'b0;
    carry_in    = 1'b0;
    start_in    = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    @(posedge clk_in); #1;
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    checks++;
    if ({valid_out, result_out, carry_out,
         overflow_out, zero_out} !== '0 ||
        ready_out !== 1'b1) begin
      failures++;
      $display("FAIL midrun_reset got=%h v%b c%b o%b z%b r%b exp=0 r1",
               result_out, valid_out, carry_out,
               overflow_out, zero_out, ready_out);
    end
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_in); #1;
      if (valid_out) nv++;
    end
    checks++;
    if (nv !== 0) begin
      failures++;
      $display("FAIL midrun_no_valid got=%0d exp=0", nv);
    end
    e = model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
           lat, g);
    checks++;
    if (lat !== LAT || g.res !== 32'h2345_6789 ||
        g.res !== e.res) begin
      failures++;
      $display("FAIL midrun_after lat=%0d got=%h exp=23456789",
               lat, g.res);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_corners();
    test_random();
    test_start_held();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, total operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 8, bits added per clock cycle; WIDTH % SLICE == 0 and SLICE >= 1 are required.
REQ-003 SHALL have port clk_in, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start_in, input, 1, request to begin an operation.
REQ-006 SHALL have port ready_out, output, 1, high when a start_in will be accepted.
REQ-007 SHALL have port operand1_in, input, WIDTH, first operand, sampled on accept.
REQ-008 SHALL have port operand2_in, input, WIDTH, second operand, sampled on accept.
REQ-009 SHALL have port subtract_in, input, 1, 0 = add, 1 = operand1 - operand2, sampled on accept.
REQ-010 SHALL have port carry_in, input, 1, carry into bit 0 for add, sampled on accept; ignored for subtract.
REQ-011 SHALL have port valid_out, output, 1, one-cycle pulse marking result completion.
REQ-012 SHALL have port result_out, output, WIDTH, sum/difference.
REQ-013 SHALL have port carry_out, output, 1, carry out of bit WIDTH-1 (for subtract: 1 = no borrow).
REQ-014 SHALL have port overflow_out, output, 1, signed two's-complement overflow.
REQ-015 SHALL have port zero_out, output, 1, result_out == 0.

Function
REQ-016 SHALL implement states IDLE and RUN; NSLICES = WIDTH/SLICE.
REQ-017 SHALL drive ready_out high exactly in IDLE.
REQ-018 SHALL accept an operation when start_in && ready_out at a rising edge: latch operands, mode, and initial carry; clear the slice counter; go to RUN.
REQ-019 SHALL, for subtract, add the bitwise inverse of operand2 with initial carry forced to 1.
REQ-020 SHALL, in RUN, add one SLICE-bit slice per cycle from LSB upward, propagating carry through a registered carry bit.
REQ-021 SHALL write each slice sum into its result position; result_out is undefined-free (holds previous bits) until completion.
REQ-022 SHALL, on the cycle the last slice is written, return to IDLE and assert valid_out for exactly one cycle; latency from accept edge to valid_out high is NSLICES cycles.
REQ-023 SHALL hold result_out, carry_out, overflow_out, and zero_out stable from valid_out until the next accepted operation completes.
REQ-024 SHALL ignore start_in while in RUN; no queuing.
REQ-025 SHALL accept a start_in in the same cycle that valid_out is high (back-to-back throughput of one operation per NSLICES+1 cycles is not required; accept occurs in IDLE).
REQ-026 SHALL compute overflow_out as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-027 SHALL, when SLICE == WIDTH, complete in 1 cycle with identical behaviour.

Reset
REQ-028 SHALL, while reset_in is high at a clock edge, enter IDLE and clear result_out, carry_out, overflow_out, zero_out, valid_out, and the slice counter to 0; ready_out is 1 after reset.
REQ-029 SHALL abandon any in-flight operation on reset with no valid_out pulse; reset has priority over start_in.

Configuration
REQ-030 SHALL, with macro MULTICYCLE_ADDER_FLAGS_EN defined, compute overflow_out and zero_out as specified.
REQ-031 SHALL, without MULTICYCLE_ADDER_FLAGS_EN, tie overflow_out and zero_out to constant 0 with no flag logic; carry_out remains functional.

Structure
REQ-032 SHALL place the IDLE/RUN state enum and the default WIDTH and SLICE constants in shared package adder_pkg.
REQ-033 SHALL use one sub-module, adder_slice: a combinational SLICE-bit adder with carry in and out, and the MSB carry-in exposed for overflow detection.

Verification (WIDTH=32, SLICE=8)
REQ-034 SHALL cover: add 0xFFFFFFFF + 0x00000001, cin=0 -> valid_out 4 cycles after accept, result 0x00000000, carry 1, zero 1, overflow 0.
REQ-035 SHALL cover: subtract 5 - 7 -> result 0xFFFFFFFE, carry 0, overflow 0, zero 0.
REQ-036 SHALL cover: add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, carry 0.
REQ-037 SHALL cover: start_in held high during RUN with different operands -> the first operation's result is unchanged and there is exactly one valid_out per accept.
REQ-038 SHALL cover: reset_in asserted in the 2nd RUN cycle -> no valid_out, all outputs 0, ready_out 1 on the next cycle, and a new add 0x12345678 + 0x11111111 yields 0x23456789.
REQ-039 SHALL cover: build without MULTICYCLE_ADDER_FLAGS_EN and repeat REQ-036 -> overflow_out 0, zero_out 0, result and carry unchanged.
